// File: rtl/splio_rx_pkg.sv
// Shared constants and state encoding for the SPLIO LED-chain receiver.
package splio_rx_pkg;

    localparam int SPLIO_WIDTH = 32;

    // First bit on the wire ends up in the MSB of the parallel word.
    localparam bit MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Counter increment that sticks at lim.
    function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic [5:0] lim);
        return (v >= lim) ? lim : v + 6'd1;
    endfunction

endpackage

// File: rtl/splio_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a single-flop rise detector.
module splio_rx_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Sync chain and previous-level flop; reset to the pin's idle level so release makes no edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/splio_rx.sv
// Receiver for the SPLIO serial LED stream: rebuilds the shifted parallel word and flags bad frames.
//
// state    | meaning
// ST_IDLE  | no bits received since last latch / clear
// ST_SHIFT | collecting bits, waiting for LED_PEN rise
// ST_LATCH | frame just latched; data_valid high for this one cycle
module splio_rx
    import splio_rx_pkg::*;
#(
    parameter int WIDTH       = SPLIO_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_clk,
    input  logic             led_sout,
    input  logic             led_clrn,
    input  logic             LED_PEN,
    output logic [WIDTH-1:0] P_Data,
    output logic             data_valid,
    output logic             frame_err,
    output logic [5:0]       bit_cnt
);

    localparam logic [5:0] CNT_FULL = 6'(WIDTH);
    localparam logic [5:0] CNT_MAX  = 6'(WIDTH + 1);

    state_t                 state;
    logic [WIDTH-1:0]       shift_reg;
    logic [WIDTH-1:0]       shift_next;
    logic [5:0]             cnt_next;
    logic [SYNC_STAGES-1:0] sout_q;
    logic                   sout_sync;
    logic                   clk_lvl, clk_rise;
    logic                   pen_lvl, pen_rise;
    logic                   clrn_lvl, clrn_rise;
    logic                   unused_ok;

    splio_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst(rst), .din(led_clk), .level(clk_lvl), .rise(clk_rise)
    );

    splio_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clrn (
        .clk(clk), .rst(rst), .din(led_clrn), .level(clrn_lvl), .rise(clrn_rise)
    );

    splio_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pen (
        .clk(clk), .rst(rst), .din(LED_PEN), .level(pen_lvl), .rise(pen_rise)
    );

    assign unused_ok = &{1'b0, clk_lvl, pen_lvl, clrn_rise};

    // Data pin needs only a level synchroniser, same depth as the clock so they stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sout_q <= '0;
        else      sout_q <= {sout_q[SYNC_STAGES-2:0], led_sout};
    end

    assign sout_sync  = sout_q[SYNC_STAGES-1];
    assign shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], sout_sync}
                                  : {sout_sync, shift_reg[WIDTH-1:1]};
    assign cnt_next   = sat_inc(bit_cnt, CNT_MAX);

    // Frame FSM; the latch happens on the edge entering ST_LATCH so a same-cycle bit is included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            P_Data     <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (!clrn_lvl) begin
                state     <= ST_IDLE;
                shift_reg <= '0;
                bit_cnt   <= '0;
                frame_err <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (clk_rise) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= cnt_next;
                            if (pen_rise) begin
                                P_Data     <= shift_next;
                                data_valid <= 1'b1;
                                frame_err  <= 1'b1;
                                state      <= ST_LATCH;
                            end else begin
                                state <= ST_SHIFT;
                            end
                        end else if (pen_rise) begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_rise) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= cnt_next;
                        end
                        if (pen_rise) begin
                            P_Data     <= clk_rise ? shift_next : shift_reg;
                            data_valid <= 1'b1;
                            state      <= ST_LATCH;
                            if (clk_rise || bit_cnt != CNT_FULL) frame_err <= 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                        if (clk_rise) frame_err <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_splio_rx.sv
// Randomised scoreboard bench for splio_rx with a bit-history reference model.
module tb_splio_rx;

    localparam int W = 32;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          led_clk = 1'b0;
    logic          led_sout = 1'b0;
    logic          led_clrn = 1'b1;
    logic          LED_PEN = 1'b0;
    logic [W-1:0]  P_Data;
    logic          data_valid;
    logic          frame_err;
    logic [5:0]    bit_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [32:0]   exp_q[$];
    logic [31:0]   hist = '0;
    bit            sticky = 1'b0;
    bit            prev_dv = 1'b0;

    splio_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .led_clk(led_clk), .led_sout(led_sout),
        .led_clrn(led_clrn), .LED_PEN(LED_PEN), .P_Data(P_Data),
        .data_valid(data_valid), .frame_err(frame_err), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit b);
        led_sout = b;
        step(2);
        led_clk = 1'b1;
        step(4);
        led_clk = 1'b0;
        step(4);
    endtask

    task automatic clrn_pulse();
        led_clrn = 1'b0;
        step(5);
        led_clrn = 1'b1;
        step(5);
        hist   = '0;
        sticky = 1'b0;
    endtask

    // Sends n bits of pat (pat[n-1] first) and a LED_PEN rise; simul puts the last bit on the PEN edge.
    task automatic send_frame(input logic [39:0] pat, input int n, input bit simul);
        int          lat;
        int          nb;
        logic [63:0] ext;
        logic [63:0] mask;
        nb = simul ? n - 1 : n;
        for (int i = n - 1; i >= n - nb; i--) send_bit(pat[i]);
        if (!simul && n > 0) chk("bit_cnt_before_pen", 64'(bit_cnt), 64'((n > W + 1) ? W + 1 : n));
        mask = (64'd1 << n) - 64'd1;
        ext  = ({32'b0, hist} << n) | (64'(pat) & mask);
        hist = ext[31:0];
        sticky = sticky | simul | (n != W);
        if (n > 0) exp_q.push_back({hist, sticky});
        if (simul) begin
            led_sout = pat[0];
            step(2);
            led_clk = 1'b1;
        end
        LED_PEN = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (data_valid && lat == 0) lat = k;
        end
        chk("dv_latency", 64'(lat), 64'((n > 0) ? S + 1 : 0));
        led_clk = 1'b0;
        LED_PEN = 1'b0;
        step(6);
    endtask

    // Monitor: every data_valid pops one expected {P_Data, frame_err} from the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid) begin
                checks++;
                if (prev_dv) begin
                    errors++;
                    $display("FAIL dv_consecutive: got 1 expected 0");
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dv: got P_Data %0h expected no data_valid", P_Data);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({P_Data, frame_err} !== e) begin
                        errors++;
                        $display("FAIL frame: got data %0h err %0b expected data %0h err %0b",
                                 P_Data, frame_err, e[32:1], e[0]);
                    end
                end
            end
            prev_dv = data_valid;
        end else begin
            prev_dv = 1'b0;
        end
    end

    initial begin
        logic [39:0] pat;
        logic [7:0]  byte_v;
        int          n;
        bit          sim;

        step(3);
        chk("reset_P_Data", 64'(P_Data), 64'd0);
        chk("reset_dv", 64'(data_valid), 64'd0);
        chk("reset_err", 64'(frame_err), 64'd0);
        chk("reset_bit_cnt", 64'(bit_cnt), 64'd0);
        rst = 1'b1;
        step(3);

        // Clean 32-bit frame after a clear.
        clrn_pulse();
        send_frame({8'h00, 32'hFFFFFF5A}, 32, 1'b0);
        chk("clean_err", 64'(frame_err), 64'd0);

        // Short frame: latched but flagged, and the flag is sticky.
        send_frame({8'h00, 32'h1234_5678}, 31, 1'b0);
        chk("short_err", 64'(frame_err), 64'd1);
        send_frame({8'h00, 32'hA5A5_0F0F}, 32, 1'b0);
        chk("sticky_err", 64'(frame_err), 64'd1);
        clrn_pulse();
        chk("clrn_err", 64'(frame_err), 64'd0);
        chk("clrn_bit_cnt", 64'(bit_cnt), 64'd0);

        // Overrun: 33 bits, older bit falls off the MSB.
        send_frame(40'h01_0000_0001, 33, 1'b0);
        chk("overrun_err", 64'(frame_err), 64'd1);
        clrn_pulse();

        // Loopback pattern: decoder outputs stepped, back-to-back frames.
        for (int k = 0; k < 8; k++) begin
            byte_v = ~(8'h01 << k);
            pat    = {8'h00, 24'hFFFFFF, byte_v};
            send_frame(pat, 32, 1'b0);
        end
        chk("loopback_err", 64'(frame_err), 64'd0);

        // Same-cycle clock and PEN rise, then a clean frame.
        send_frame({8'h00, 32'hC3C3_3C3C}, 32, 1'b1);
        chk("simul_err", 64'(frame_err), 64'd1);
        send_frame({8'h00, 32'hDEAD_BEEF}, 32, 1'b0);
        clrn_pulse();
        send_frame({8'h00, 32'h0BAD_F00D}, 32, 1'b0);
        send_frame({8'h00, 32'h1111_2222}, 30, 1'b0);

        // Reset mid-frame: outputs clear at once, no latch after release.
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        #2 rst = 1'b0;
        #1;
        chk("async_P_Data", 64'(P_Data), 64'd0);
        chk("async_err", 64'(frame_err), 64'd0);
        chk("async_bit_cnt", 64'(bit_cnt), 64'd0);
        chk("async_dv", 64'(data_valid), 64'd0);
        step(3);
        rst = 1'b1;
        hist   = '0;
        sticky = 1'b0;
        step(3);
        send_frame(40'h0, 0, 1'b0);
        chk("idle_pen_err", 64'(frame_err), 64'd1);
        clrn_pulse();

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            pat = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       n = 31;
                1:       n = 33;
                2:       n = 30;
                3:       n = 34;
                default: n = 32;
            endcase
            sim = ($urandom_range(0, 9) == 0);
            send_frame(pat, n, sim);
            if ($urandom_range(0, 4) == 0) clrn_pulse();
        end

        step(10);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
